mosr_linebuf: RTL
=================

MOSR_LINEBUF -- requirements
Module: mosr_linebuf

Interface
REQ-001 Parameter LINE_W, default 336: visible pixels per line; columns at or above LINE_W are never written.
REQ-002 Parameter PIPE_LAT, default 3: cycles from obj_ld to the first valid MOSR pixel, range 1..7.
REQ-003 Port sysclk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port MOSR, input, 7: serialized motion-object pixel stream from the graphics cart; bits [3:0] colour, [6:4] palette.
REQ-006 Port obj_ld, input, 1: one-cycle pulse marking the load of an 8-pixel motion-object stripe.
REQ-007 Port obj_x, input, 9: start column of the stripe, sampled with obj_ld.
REQ-008 Port line_swap, input, 1: one-cycle pulse at horizontal blank that exchanges the write and read banks.
REQ-009 Port rd_en, input, 1: read strobe for the display side.
REQ-010 Port rd_x, input, 9: column to read, sampled with rd_en.
REQ-011 Port rd_pix, output, 7: pixel read from the read bank, registered.
REQ-012 Port busy, output, 1: high while a stripe is pending or being written.
REQ-013 Port ovf, output, 1: sticky flag, set when an obj_ld is dropped.

Function
REQ-014 The block SHALL hold two banks of 512 entries; each entry is 7 data bits plus 1 valid bit.
REQ-015 wr_bank SHALL select the write bank; the read bank SHALL always be ~wr_bank.
REQ-016 The write FSM SHALL have states IDLE, WAIT and WRITE.
REQ-017 In IDLE, obj_ld SHALL latch obj_x, load the latency counter with PIPE_LAT-1, and move to WAIT; if PIPE_LAT is 1, the FSM SHALL go directly to WRITE.
REQ-018 WAIT SHALL decrement the counter each cycle and move to WRITE when the counter reaches 0.
REQ-019 WRITE SHALL last exactly 8 cycles; on cycle k (0..7), MOSR is written to column (x+k) mod 512 of the write bank.
REQ-020 A pixel SHALL be treated as transparent when MOSR[3:0]==4'hF; transparent pixels SHALL NOT be written.
REQ-021 A pixel whose column is at or above LINE_W SHALL NOT be written; the column address wraps modulo 512.
REQ-022 An obj_ld on WRITE cycle 7 SHALL be accepted seamlessly, exactly as it would be in IDLE.
REQ-023 An obj_ld at any other time while busy SHALL be ignored, and ovf SHALL be set.
REQ-024 busy SHALL be high exactly when the FSM is not in IDLE.
REQ-025 line_swap SHALL toggle wr_bank, abort any stripe in progress, and return the FSM to IDLE.
REQ-026 When obj_ld and line_swap occur in the same cycle, the swap SHALL apply first and the obj_ld SHALL be accepted into the new write bank.
REQ-027 On rd_en, rd_pix SHALL update one cycle later: the entry data if valid, else 7'h7F.
REQ-028 On rd_en, the valid bit of the read entry SHALL be cleared in the same cycle (erase-on-read).
REQ-029 With rd_en low, rd_pix SHALL hold its value.
REQ-030 The write side and the read side SHALL never address the same bank, so no read/write collision exists.

Reset
REQ-031 Reset SHALL set wr_bank=0, FSM=IDLE, busy=0, ovf=0 and rd_pix=7'h7F.
REQ-032 Reset SHALL clear all valid bits in both banks; data bits are don't-care.
REQ-033 Reset asserted mid-stripe SHALL abort the stripe; no write SHALL occur in the reset cycle.

Configuration
REQ-034 The macro MOSR_PRIORITY_EN SHALL control write priority.
REQ-035 With MOSR_PRIORITY_EN defined, a non-transparent pixel SHALL be written only when the target entry is invalid (first-written wins).
REQ-036 Without MOSR_PRIORITY_EN, a non-transparent pixel SHALL always overwrite the entry (last-written wins).

Verification
REQ-037 Reset, swap, then read columns 0..LINE_W-1 -> all reads return 7'h7F.
REQ-038 obj_ld with obj_x=10 and PIPE_LAT=3; MOSR 7'h01..7'h08 on cycles 3..10; swap; read columns 10..17 -> 7'h01..7'h08; re-read -> 7'h7F.
REQ-039 obj_x=508 with 8 opaque pixels -> columns 508..511 are not written (at or above LINE_W); columns 0..3 hold pixels 4..7.
REQ-040 Stripe A at x=20 (7'h11); overlapping stripe B at x=20 (7'h22) launched back-to-back -> 7'h11 with MOSR_PRIORITY_EN defined, 7'h22 without; ovf=0.
REQ-041 obj_ld during WAIT -> ovf=1, the first stripe completes intact; line_swap during WRITE -> busy=0 next cycle and the remaining pixels are not written.
REQ-042 MOSR[3:0]=4'hF on alternate pixels of a stripe at x=40 -> the skipped columns read 7'h7F; the other columns read their pixel values.

Source files
------------

// File: rtl/mosr_linebuf.sv
// mosr_linebuf: double-banked motion-object line buffer fed by the serialized MOSR stream
// Ports: sysclk/reset (sync, active-high); MOSR pixel stream; obj_ld/obj_x launch an 8-pixel stripe;
// line_swap exchanges banks; rd_en/rd_x read with erase-on-read into registered rd_pix;
// busy while a stripe is pending or written; ovf sticky on a dropped obj_ld.
// Macro MOSR_PRIORITY_EN: first-written pixel wins instead of last-written.
module mosr_linebuf #(
  parameter int LINE_W = 336,
  parameter int PIPE_LAT = 3
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [6:0] MOSR,
  input  logic       obj_ld,
  input  logic [8:0] obj_x,
  input  logic       line_swap,
  input  logic       rd_en,
  input  logic [8:0] rd_x,
  output logic [6:0] rd_pix,
  output logic       busy,
  output logic       ovf
);
  typedef enum logic [1:0] {IDLE, WAIT, WRITE} st_t;
  st_t st, st_n;
  logic [2:0] cnt, cnt_n, k, k_n;
  logic [8:0] x, x_n, col;
  logic bank, bank_n, ovf_n, acc, we, pri_ok;
  logic [6:0] dat [1024];
  logic [511:0] vld [2];
  assign col = x + {6'd0, k};
  // A swap frees the FSM in the same cycle, so a coincident obj_ld is accepted like WRITE cycle 7 or IDLE.
  assign acc = line_swap || st == IDLE || (st == WRITE && k == 3'd7);
`ifdef MOSR_PRIORITY_EN
  assign pri_ok = !vld[bank][col];
`else
  assign pri_ok = 1'b1;
`endif
  // The swap cycle belongs to the aborted stripe, so nothing is written then.
  assign we = st == WRITE && !line_swap && MOSR[3:0] != 4'hF && {23'd0, col} < LINE_W && pri_ok;
  assign busy = st != IDLE;
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    k_n = k;
    x_n = x;
    bank_n = line_swap ? ~bank : bank;
    ovf_n = ovf;
    if (st == WAIT) begin
      cnt_n = cnt - 3'd1;
      if (cnt == 3'd1) begin
        st_n = WRITE;
        k_n = 3'd0;
      end
    end
    if (st == WRITE) begin
      k_n = k + 3'd1;
      if (k == 3'd7) st_n = IDLE;
    end
    if (line_swap) st_n = IDLE;
    if (obj_ld && acc) begin
      x_n = obj_x;
      cnt_n = 3'(PIPE_LAT - 1);
      k_n = 3'd0;
      st_n = (PIPE_LAT == 1) ? WRITE : WAIT;
    end
    if (obj_ld && !acc) ovf_n = 1'b1;
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      k <= '0;
      x <= '0;
      bank <= 1'b0;
      ovf <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      k <= k_n;
      x <= x_n;
      bank <= bank_n;
      ovf <= ovf_n;
    end
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      vld[0] <= '0;
      vld[1] <= '0;
      rd_pix <= 7'h7F;
    end else begin
      if (we) vld[bank][col] <= 1'b1;
      if (rd_en) begin
        vld[~bank][rd_x] <= 1'b0;
        rd_pix <= vld[~bank][rd_x] ? dat[{~bank, rd_x}] : 7'h7F;
      end
    end
  end
  always_ff @(posedge sysclk) begin
    if (we) dat[{bank, col}] <= MOSR;
  end
endmodule
